// File: rtl/calc_pkg.sv
// Shared calculator control encodings: FSM state / 7-seg codes, ALU ops,
// MUX selects and register-file indices. Used by control_unit and mult_sequencer.
package calc_pkg;

  // State encoding doubles as the 7-seg CS code
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_A   = 4'd1,
    ST_LD_B   = 4'd2,
    ST_LD_ONE = 4'd3,
    ST_CLR    = 4'd4,
    ST_CHECK  = 4'd5,
    ST_ADD    = 4'd6,
    ST_DEC    = 4'd7,
    ST_OUT    = 4'd8,
    ST_DONE   = 4'd9
  } state_t;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // MUX1 (regfile write data) selects
  localparam logic [1:0] M1_IN1 = 2'b00;
  localparam logic [1:0] M1_IN2 = 2'b01;
  localparam logic [1:0] M1_ALU = 2'b10;
  localparam logic [1:0] M1_ONE = 2'b11;

  // MUX2 (result output) selects
  localparam logic M2_ZERO = 1'b0;
  localparam logic M2_ALU  = 1'b1;

  // Register map: operand A, B / loop count, accumulator, constant 1
  localparam logic [1:0] R_A   = 2'd0;
  localparam logic [1:0] R_B   = 2'd1;
  localparam logic [1:0] R_ACC = 2'd2;
  localparam logic [1:0] R_ONE = 2'd3;

endpackage

// File: rtl/calc_go_edge.sv
// Rising-edge detector for the go request. go_q clears on reset, so a go
// held high through reset reads as a fresh edge on the first cycle after.
module calc_go_edge (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic rise
);

  logic go_q;

  // Delayed copy of go, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) go_q <= 1'b0;
    else      go_q <= go;
  end

  assign rise = go & ~go_q;

endmodule

// File: rtl/mult_sequencer.sv
// Drives the calculator datapath control lines to form A*B by repeated
// addition. Only ALU status flags are read back; data bits are never seen.
// Optional: define MULT_OVF_DET_EN to flag ALU carry-out during ADD as ovf.
module mult_sequencer
  import calc_pkg::*;
#(
  parameter int ITER_LIMIT  = 15,
  parameter int DONE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       alu_zero,
  input  logic       alu_cout,
  output logic [1:0] s1,
  output logic [1:0] WA,
  output logic       WE,
  output logic [1:0] RAA,
  output logic [1:0] RAB,
  output logic       REA,
  output logic       REB,
  output logic [1:0] C,
  output logic       s2,
  output logic [3:0] CS,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic       ovf
);

  localparam int IW = $clog2(ITER_LIMIT + 1);
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_t          state, nxt;
  logic [IW-1:0]   iter;
  logic [DW-1:0]   dcnt;
  logic            start;
  logic            iter_hit;

  calc_go_edge u_go_edge (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .rise (start)
  );

  assign iter_hit = (iter == IW'(ITER_LIMIT));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = ST_LD_A;
      ST_LD_A:   nxt = ST_LD_B;
      ST_LD_B:   nxt = ST_LD_ONE;
      ST_LD_ONE: nxt = ST_CLR;
      ST_CLR:    nxt = ST_CHECK;
      ST_CHECK:  nxt = alu_zero ? ST_OUT : ST_ADD;
      ST_ADD:    nxt = ST_DEC;
      ST_DEC:    nxt = (alu_zero || iter_hit) ? ST_OUT : ST_ADD;
      ST_OUT:    nxt = ST_DONE;
      ST_DONE:   if (dcnt == DW'(DONE_CYCLES - 1)) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Iteration count, iteration-limit fault and DONE hold counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      iter <= '0;
      err  <= 1'b0;
      dcnt <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        iter <= '0;
        err  <= 1'b0;
      end
      if (state == ST_ADD) iter <= iter + 1'b1;
      // Fault only when the count would have continued; a zero result wins
      if (state == ST_DEC && !alu_zero && iter_hit) err <= 1'b1;
      dcnt <= (state == ST_DONE) ? dcnt + 1'b1 : '0;
    end
  end

`ifdef MULT_OVF_DET_EN
  // Sticky product overflow: any carry out of an accumulate step
  always_ff @(posedge clk) begin
    if (!rst)                          ovf <= 1'b0;
    else if (state == ST_IDLE && start) ovf <= 1'b0;
    else if (state == ST_ADD && alu_cout) ovf <= 1'b1;
  end
`else
  logic unused_cout;
  assign unused_cout = alu_cout;
  assign ovf         = 1'b0;
`endif

  // Datapath control decode per state
  always_comb begin
    s1   = M1_IN1;
    WA   = 2'd0;
    WE   = 1'b0;
    RAA  = 2'd0;
    RAB  = 2'd0;
    REA  = 1'b0;
    REB  = 1'b0;
    C    = ALU_ADD;
    s2   = M2_ZERO;
    done = 1'b0;
    case (state)
      ST_LD_A:   begin s1 = M1_IN1; WA = R_A;   WE = 1'b1; end
      ST_LD_B:   begin s1 = M1_IN2; WA = R_B;   WE = 1'b1; end
      ST_LD_ONE: begin s1 = M1_ONE; WA = R_ONE; WE = 1'b1; end
      ST_CLR: begin
        RAA = R_A; RAB = R_A; REA = 1'b1; REB = 1'b1;
        C = ALU_SUB; s1 = M1_ALU; WA = R_ACC; WE = 1'b1;
      end
      ST_CHECK: begin
        RAA = R_B; RAB = R_B; REA = 1'b1; REB = 1'b1; C = ALU_AND;
      end
      ST_ADD: begin
        RAA = R_ACC; RAB = R_A; REA = 1'b1; REB = 1'b1;
        C = ALU_ADD; s1 = M1_ALU; WA = R_ACC; WE = 1'b1;
      end
      ST_DEC: begin
        RAA = R_B; RAB = R_ONE; REA = 1'b1; REB = 1'b1;
        C = ALU_SUB; s1 = M1_ALU; WA = R_B; WE = 1'b1;
      end
      ST_OUT, ST_DONE: begin
        RAA = R_ACC; RAB = R_ACC; REA = 1'b1; REB = 1'b1;
        C = ALU_AND; s2 = M2_ALU;
        done = (state == ST_DONE);
      end
      default: ;
    endcase
  end

  assign CS   = state;
  assign busy = (state != ST_IDLE);

endmodule
